branch_resolver: RTL

- Consumer side of the condition codes: samples N/Z/P together with the fetched IR and PC, and decides whether control flow changes.
- Decodes BR, JMP/RET and JSR/JSRR, computes the target address, and drives BEN to the control FSM.
- Presents the redirect PC to fetch on a valid/ready handshake; for JSR/JSRR it also issues a one-cycle R7 link write.
- Sits between the NZP register, the register file (SR1 read port), the control FSM and the PC mux.

---
 rtl/lc3_pkg.sv | 17 +
 rtl/branch_target_calc.sv | 39 +++
 rtl/branch_resolver.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 control-flow definitions: opcodes, resolver states and offset widths.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam int OFF9_W  = 9;
    localparam int OFF11_W = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target-address generator for BR, JSR/JSRR and JMP/RET.
// Also flags the unconditional transfers (JSR/JSRR, JMP/RET).
module branch_target_calc
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       i_opcode,
    input  logic [11:0]      i_ir,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_base_r,
    output logic [WIDTH-1:0] o_target,
    output logic             o_taken_uncond
);

    logic [WIDTH-1:0] w_off9;
    logic [WIDTH-1:0] w_off11;

    assign w_off9  = {{(WIDTH-OFF9_W){i_ir[OFF9_W-1]}},   i_ir[OFF9_W-1:0]};
    assign w_off11 = {{(WIDTH-OFF11_W){i_ir[OFF11_W-1]}}, i_ir[OFF11_W-1:0]};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_target       = i_pc + w_off9;
        o_taken_uncond = 1'b0;
        case (i_opcode)
            OP_JSR: begin
                o_taken_uncond = 1'b1;
                o_target       = i_ir[11] ? (i_pc + w_off11) : i_base_r;
            end
            OP_JMP: begin
                o_taken_uncond = 1'b1;
                o_target       = i_base_r;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Captures IR/NZP/PC/base on LD_BEN, resolves BEN in one EVAL cycle, then holds the
// redirect on a valid/ready handshake and issues a one-cycle R7 link strobe for JSR/JSRR.
module branch_resolver
    import lc3_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LINK_EN = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             LD_BEN,
    input  logic [WIDTH-1:0] IR,
    input  logic             N_IN,
    input  logic             Z_IN,
    input  logic             P_IN,
    input  logic [WIDTH-1:0] PC_IN,
    input  logic [WIDTH-1:0] BASE_R,
    input  logic             REDIRECT_READY,
    output logic             BEN,
    output logic             REDIRECT_VALID,
    output logic [WIDTH-1:0] REDIRECT_PC,
    output logic             LINK_VALID,
    output logic [WIDTH-1:0] LINK_PC,
    output logic             BUSY
);

    localparam bit LINK_ON = (LINK_EN != 0);

    state_t           r_state;
    logic [WIDTH-1:0] r_ir;
    logic [2:0]       r_nzp;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_base;
    logic             r_ben;
    logic             r_redirect_valid;
    logic [WIDTH-1:0] r_redirect_pc;
    logic             r_link_valid;
    logic [WIDTH-1:0] r_link_pc;

    logic [3:0]       w_opcode;
    logic [WIDTH-1:0] w_target;
    logic             w_taken_uncond;
    logic             w_br_taken;
    logic             w_taken;
    logic             w_is_jsr;

    assign w_opcode   = r_ir[15:12];
    // Flags are used raw: multiple set bits simply OR together, all-zero never matches.
    assign w_br_taken = (w_opcode == OP_BR) && (|(r_ir[11:9] & r_nzp));
    assign w_taken    = w_br_taken | w_taken_uncond;
    assign w_is_jsr   = (w_opcode == OP_JSR);

    branch_target_calc #(.WIDTH(WIDTH)) u_target (
        .i_opcode       (w_opcode),
        .i_ir           (r_ir[11:0]),
        .i_pc           (r_pc),
        .i_base_r       (r_base),
        .o_target       (w_target),
        .o_taken_uncond (w_taken_uncond)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state          <= IDLE;
            r_ir             <= '0;
            r_nzp            <= '0;
            r_pc             <= '0;
            r_base           <= '0;
            r_ben            <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_link_valid     <= 1'b0;
            r_link_pc        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (LD_BEN) begin
                        r_ir    <= IR;
                        r_nzp   <= {N_IN, Z_IN, P_IN};
                        r_pc    <= PC_IN;
                        r_base  <= BASE_R;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    r_ben <= w_taken;
                    if (w_taken) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_target;
                        if (w_is_jsr && LINK_ON) begin
                            r_link_valid <= 1'b1;
                            r_link_pc    <= r_pc;
                        end
                        r_state <= REDIRECT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REDIRECT: begin
                    // The link strobe lives for exactly the first REDIRECT cycle, stalls or not.
                    r_link_valid <= 1'b0;
                    if (REDIRECT_READY) begin
                        r_redirect_valid <= 1'b0;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign BEN            = r_ben;
    assign REDIRECT_VALID = r_redirect_valid;
    assign REDIRECT_PC    = r_redirect_pc;
    assign LINK_VALID     = r_link_valid;
    assign LINK_PC        = r_link_pc;
    assign BUSY           = (r_state != IDLE);

endmodule
